// File: rtl/scope_pkg.sv
// Shared definitions for the scope capture path.
// Holds the capture FSM encoding and trigger edge select codes.
package scope_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FLUSH = 3'd1;
  localparam logic [2:0] ST_PRE   = 3'd2;
  localparam logic [2:0] ST_ARMED = 3'd3;
  localparam logic [2:0] ST_POST  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

endpackage

// File: rtl/adc_clk_gen.sv
// ADC conversion clock divider and sample strobe generator.
// Ports: clk/rst, en (run), clr (restart at 0), adc_clk, strobe.
module adc_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic adc_clk,
  output logic strobe
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] div_cnt_q;
  logic [CW-1:0] div_cnt_d;
  logic          last;

  assign last = (div_cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clr || !en) begin
      div_cnt_d = '0;
    end else if (last) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  // Held low while idle so the ADC sees a quiet clock pin.
  assign adc_clk = en && (div_cnt_q < CW'(CLK_DIV / 2));
  assign strobe  = en && last;

endmodule

// File: rtl/adc_capture_ctrl.sv
// ADC capture sequencer: flush, pre-trigger, trigger, post-trigger.
// Ports: CLK/RST, ADC pins, ARM/FORCE_TRIG/trigger setup, status, RAM write port.
module adc_capture_ctrl
  import scope_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int ADDR_W    = 10,
  parameter int PRE_DEPTH = 256,
  parameter int ADC_LAT   = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        ADC_D,
  output logic              ADC_CLK,
  output logic              ADC_nOE,
  input  logic              ARM,
  input  logic              FORCE_TRIG,
  input  logic [7:0]        TRIG_LEVEL,
  input  logic              TRIG_EDGE,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] TRIG_ADDR,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [7:0]        WR_DATA
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int CMAX   = (ADC_LAT > DEPTH) ? ADC_LAT : DEPTH;
  localparam int CNT_W  = $clog2(CMAX + 1);
  localparam int POST_W = DEPTH - PRE_DEPTH;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [7:0]        cur_q, cur_d;
  logic              wr_en_q, wr_en_d;
  logic              force_q, force_d;
  logic              clr;
  logic              strobe;
  logic              rise_hit, fall_hit, trig_hit;
  logic [2:0]        arm_next;

  adc_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk    (CLK),
    .rst    (RST),
    .en     (state_q != ST_IDLE),
    .clr    (clr),
    .adc_clk(ADC_CLK),
    .strobe (strobe)
  );

  // cur_q still holds the last written sample when the new one arrives.
  assign rise_hit = (cur_q < TRIG_LEVEL) && (ADC_D >= TRIG_LEVEL);
  assign fall_hit = (cur_q >= TRIG_LEVEL) && (ADC_D < TRIG_LEVEL);
  assign trig_hit = force_q ||
                    ((TRIG_EDGE == EDGE_RISE) ? rise_hit : fall_hit);
  assign arm_next = (ADC_LAT == 0) ? ST_PRE : ST_FLUSH;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_addr_d   = wr_addr_q;
    trig_addr_d = trig_addr_q;
    cur_d       = cur_q;
    wr_en_d     = 1'b0;
    force_d     = force_q;
    clr         = 1'b0;

    if (wr_en_q) wr_addr_d = wr_addr_q + ADDR_W'(1);
    if (strobe)  cur_d = ADC_D;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (ARM) begin
          state_d   = arm_next;
          cnt_d     = '0;
          wr_addr_d = '0;
          force_d   = 1'b0;
          clr       = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (strobe) begin
          if (cnt_q == CNT_W'(ADC_LAT - 1)) begin
            state_d = ST_PRE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_PRE: begin
        if (strobe) begin
          wr_en_d = 1'b1;
          if (cnt_q == CNT_W'(PRE_DEPTH - 1)) begin
            state_d = ST_ARMED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_ARMED: begin
        if (FORCE_TRIG) force_d = 1'b1;
        if (strobe) begin
          wr_en_d = 1'b1;
          if (trig_hit) begin
            trig_addr_d = wr_addr_q;
            state_d     = ST_POST;
            cnt_d       = '0;
            force_d     = 1'b0;
          end
        end
      end
      ST_POST: begin
        if (strobe) wr_en_d = 1'b1;
        // Counts the trigger write too; DONE follows the last pulse.
        if (wr_en_q) begin
          if (cnt_q == CNT_W'(POST_W - 1)) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      wr_addr_q   <= '0;
      trig_addr_q <= '0;
      cur_q       <= '0;
      wr_en_q     <= 1'b0;
      force_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_addr_q   <= wr_addr_d;
      trig_addr_q <= trig_addr_d;
      cur_q       <= cur_d;
      wr_en_q     <= wr_en_d;
      force_q     <= force_d;
    end
  end

  assign ADC_nOE   = (state_q == ST_IDLE);
  assign BUSY      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign DONE      = (state_q == ST_DONE);
  assign TRIG_ADDR = trig_addr_q;
  assign WR_EN     = wr_en_q;
  assign WR_ADDR   = wr_addr_q;
  assign WR_DATA   = cur_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl.
// Drives sample streams and compares against a capture-rule model.
module tb_adc_capture_ctrl;

  localparam int CLK_DIV   = 4;
  localparam int ADDR_W    = 4;
  localparam int PRE_DEPTH = 4;
  localparam int ADC_LAT   = 2;
  localparam int DEPTH     = 16;
  localparam int POST_N    = DEPTH - PRE_DEPTH - 1;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [7:0]        ADC_D = 8'd0;
  logic              ADC_CLK;
  logic              ADC_nOE;
  logic              ARM = 1'b0;
  logic              FORCE_TRIG = 1'b0;
  logic [7:0]        TRIG_LEVEL = 8'd0;
  logic              TRIG_EDGE = 1'b0;
  logic              BUSY;
  logic              DONE;
  logic [ADDR_W-1:0] TRIG_ADDR;
  logic              WR_EN;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [7:0]        WR_DATA;

  adc_capture_ctrl #(
    .CLK_DIV  (CLK_DIV),
    .ADDR_W   (ADDR_W),
    .PRE_DEPTH(PRE_DEPTH),
    .ADC_LAT  (ADC_LAT)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ADC_D     (ADC_D),
    .ADC_CLK   (ADC_CLK),
    .ADC_nOE   (ADC_nOE),
    .ARM       (ARM),
    .FORCE_TRIG(FORCE_TRIG),
    .TRIG_LEVEL(TRIG_LEVEL),
    .TRIG_EDGE (TRIG_EDGE),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .TRIG_ADDR (TRIG_ADDR),
    .WR_EN     (WR_EN),
    .WR_ADDR   (WR_ADDR),
    .WR_DATA   (WR_DATA)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  int samp [0:255];
  int lvl;
  int edg;
  int force_j;
  int arm_a;
  int arm_b;
  int rst_at;

  int wa [$];
  int wd [$];
  int wc [$];
  logic [7:0] ram [0:15];
  int done_cyc;
  int busy1;
  int done1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic capture();
    int c;
    wa.delete();
    wd.delete();
    wc.delete();
    done_cyc = -1;
    busy1 = 0;
    done1 = 1;
    TRIG_LEVEL = 8'(lvl);
    TRIG_EDGE = (edg != 0);
    ADC_D = 8'(samp[0]);
    ARM = 1'b1;
    @(posedge CLK);
    #1 ARM = 1'b0;
    c = 0;
    while (c < 800) begin
      @(negedge CLK);
      if (c == 0) begin
        busy1 = int'(BUSY);
        done1 = int'(DONE);
      end
      if (WR_EN) begin
        wa.push_back(int'(WR_ADDR));
        wd.push_back(int'(WR_DATA));
        wc.push_back(c);
        ram[WR_ADDR] = WR_DATA;
      end
      if (DONE && done_cyc < 0) done_cyc = c;
      if (done_cyc >= 0) break;
      if (c == rst_at) begin
        RST = 1'b1;
        break;
      end
      @(posedge CLK);
      c++;
      #1;
      if (c % CLK_DIV == 0 && c / CLK_DIV < 256)
        ADC_D = 8'(samp[c / CLK_DIV]);
      FORCE_TRIG = (force_j >= 0 && c == CLK_DIV * force_j + 1);
      ARM = (c == arm_a || c == arm_b);
    end
    FORCE_TRIG = 1'b0;
    ARM = 1'b0;
  endtask

  task automatic verify(input string nm);
    int tk;
    int w;
    int ta;
    logic [3:0] ix;
    tk = -1;
    for (int k = ADC_LAT + PRE_DEPTH; k < 240 && tk < 0; k++) begin
      bit r;
      bit f;
      r = samp[k-1] < lvl && samp[k] >= lvl;
      f = samp[k-1] >= lvl && samp[k] < lvl;
      if ((edg == 0 ? r : f) || (force_j >= 0 && k >= force_j)) tk = k;
    end
    w = tk - ADC_LAT + POST_N + 1;
    ta = (tk - ADC_LAT) % DEPTH;
    chk({nm, "_timeout"}, int'(done_cyc >= 0), 1);
    chk({nm, "_busy_after_arm"}, busy1, 1);
    chk({nm, "_done_after_arm"}, done1, 0);
    chk({nm, "_nwrites"}, wa.size(), w);
    for (int i = 0; i < wa.size() && i < w; i++) begin
      chk({nm, "_wr_addr"}, wa[i], i % DEPTH);
      chk({nm, "_wr_data"}, wd[i], samp[ADC_LAT + i]);
    end
    if (wa.size() > 0) begin
      chk({nm, "_first_wr_cycle"}, wc[0], CLK_DIV * (ADC_LAT + 1));
      chk({nm, "_done_timing"}, done_cyc, wc[wc.size() - 1] + 1);
    end
    chk({nm, "_trig_addr"}, int'(TRIG_ADDR), ta);
    for (int i = 0; i < DEPTH; i++) begin
      ix = 4'(ta - PRE_DEPTH + i);
      chk({nm, "_ram"}, int'(ram[ix]), samp[tk - PRE_DEPTH + i]);
    end
  endtask

  task automatic defaults();
    force_j = -1;
    arm_a = -1;
    arm_b = -1;
    rst_at = -1;
  endtask

  initial begin
    int cnt_we;
    int cnt_ck;
    int cnt_oe;
    for (int i = 0; i < 16; i++) ram[i] = 8'd0;
    defaults();

    #1;
    chk("rst_adc_clk", int'(ADC_CLK), 0);
    chk("rst_noe", int'(ADC_nOE), 1);
    chk("rst_wr_en", int'(WR_EN), 0);
    chk("rst_wr_addr", int'(WR_ADDR), 0);
    chk("rst_wr_data", int'(WR_DATA), 0);
    chk("rst_trig_addr", int'(TRIG_ADDR), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_done", int'(DONE), 0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    ADC_D = 8'd77;
    cnt_we = 0;
    cnt_ck = 0;
    cnt_oe = 0;
    repeat (50) begin
      @(negedge CLK);
      cnt_we += int'(WR_EN);
      cnt_ck += int'(ADC_CLK);
      cnt_oe += int'(!ADC_nOE);
    end
    chk("idle_wr_en", cnt_we, 0);
    chk("idle_adc_clk_high", cnt_ck, 0);
    chk("idle_noe_low", cnt_oe, 0);

    for (int k = 0; k < 256; k++) samp[k] = k;
    lvl = 10;
    edg = 0;
    capture();
    verify("ramp");

    for (int k = 0; k < 256; k++) samp[k] = (k < 6) ? 200 : 50;
    lvl = 100;
    edg = 1;
    capture();
    verify("fall");

    for (int k = 0; k < 256; k++) samp[k] = 0;
    lvl = 5;
    edg = 0;
    force_j = 10;
    capture();
    verify("force");

    defaults();
    for (int k = 0; k < 256; k++) samp[k] = (k * 3) % 256;
    lvl = 30;
    edg = 0;
    arm_a = 16;
    arm_b = 60;
    capture();
    verify("arm_ignored");
    defaults();
    chk("done_before_rearm", int'(DONE), 1);

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 256; k++) samp[k] = int'($urandom_range(0, 255));
      lvl = int'($urandom_range(20, 235));
      edg = int'($urandom_range(0, 1));
      force_j = int'($urandom_range(ADC_LAT + PRE_DEPTH, 24));
      capture();
      verify($sformatf("rand%0d", r));
    end

    defaults();
    for (int k = 0; k < 256; k++) samp[k] = k;
    lvl = 10;
    edg = 0;
    rst_at = 60;
    capture();
    #1;
    chk("midrst_adc_clk", int'(ADC_CLK), 0);
    chk("midrst_noe", int'(ADC_nOE), 1);
    chk("midrst_wr_en", int'(WR_EN), 0);
    chk("midrst_wr_addr", int'(WR_ADDR), 0);
    chk("midrst_wr_data", int'(WR_DATA), 0);
    chk("midrst_trig_addr", int'(TRIG_ADDR), 0);
    chk("midrst_busy", int'(BUSY), 0);
    chk("midrst_done", int'(DONE), 0);
    cnt_we = 0;
    repeat (3) begin
      @(negedge CLK);
      cnt_we += int'(WR_EN);
    end
    RST = 1'b0;
    repeat (40) begin
      @(negedge CLK);
      cnt_we += int'(WR_EN);
    end
    chk("midrst_no_write", cnt_we, 0);
    chk("midrst_idle_busy", int'(BUSY), 0);

    defaults();
    capture();
    verify("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
